// File: rtl/cubehash_digest_tx.sv
// cubehash_digest_tx: captures finished CubeHash digests into a two-slot
// buffer and streams each one out as HASH_W/8 bytes on a byte-wide port.
//
// Handshake contract (both sides):
//   - Digest side: a capture happens on a rising edge where hash_valid = 1
//     and hash_ready = 1. hash_ready depends only on registered state, so a
//     strobe that arrives while both slots are full is dropped and flagged in
//     the sticky overrun bit. A byte retired in that same cycle does not
//     rescue it.
//   - Byte side: a byte transfers on a rising edge where byte_valid = 1 and
//     byte_ready = 1. While byte_valid = 1 and byte_ready = 0, byte_out,
//     byte_first and byte_last hold their values. byte_valid never drops
//     without a transfer.
// Every output is a function of registered state only.
module cubehash_digest_tx #(
    parameter int HASH_W    = 256,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic [HASH_W-1:0] hash_in,
    input  logic              hash_valid,
    output logic              hash_ready,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              byte_first,
    output logic              byte_last,
    output logic              busy,
    output logic              overrun
);

    localparam int BYTES = HASH_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BYTES - 1);

    // Buffer occupancy: the encoding equals the number of filled slots.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    buf_state_e        state_q, state_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              overrun_q, overrun_d;
    logic [HASH_W-1:0] slot_q [2];
    logic [HASH_W-1:0] slot_d [2];

    logic              capture;
    logic              xfer;
    logic              retire;
    logic [IDX_W-1:0]  byte_sel;
    logic [HASH_W-1:0] rd_word;

    // Handshake qualifiers derived from the registered occupancy.
    always_comb begin
        hash_ready = (state_q != BUF_FULL);
        byte_valid = (state_q != BUF_EMPTY);
        capture    = hash_valid && hash_ready;
        xfer       = byte_valid && byte_ready;
        retire     = xfer && (idx_q == IDX_MAX);
    end

    // Next-state logic: occupancy, pointers, byte index and sticky overrun.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;

        if (hash_valid && !hash_ready) begin
            overrun_d = 1'b1;
        end

        if (capture) begin
            wr_ptr_d = ~wr_ptr_q;
        end

        if (xfer) begin
            if (retire) begin
                idx_d    = '0;
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        unique case (state_q)
            BUF_EMPTY: begin
                if (capture) begin
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (capture && !retire) begin
                    state_d = BUF_FULL;
                end else if (!capture && retire) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (retire) begin
                    state_d = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    // Control registers with asynchronous clear; a partially sent digest is abandoned.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_q   <= BUF_EMPTY;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    // Slot write: only the free slot selected by wr_ptr can be loaded.
    always_comb begin
        slot_d = slot_q;
        if (capture) begin
            slot_d[wr_ptr_q] = hash_in;
        end
    end

    // Digest storage needs no reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    // Byte select from the slot being read, plus the framing flags.
    always_comb begin
        rd_word    = slot_q[rd_ptr_q];
        byte_sel   = MSB_FIRST ? (IDX_MAX - idx_q) : idx_q;
        byte_out   = byte_valid ? rd_word[{byte_sel, 3'b000} +: 8] : 8'h00;
        byte_first = byte_valid && (idx_q == '0);
        byte_last  = byte_valid && (idx_q == IDX_MAX);
        busy       = byte_valid;
        overrun    = overrun_q;
    end

endmodule

// File: tb/tb_cubehash_digest_tx.sv
// Testbench for cubehash_digest_tx: directed scenarios followed by random
// traffic, checked by a scoreboard that holds the expected byte stream.
module tb_cubehash_digest_tx;

    localparam int HASH_W    = 256;
    localparam int BYTES     = HASH_W / 8;
    localparam bit MSB_FIRST = 1'b1;
    localparam int EW        = 10;  // {first, last, byte}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_p;
    logic [HASH_W-1:0] hash_in;
    logic              hash_valid;
    logic              hash_ready;
    logic [7:0]        byte_out;
    logic              byte_valid;
    logic              byte_ready;
    logic              byte_first;
    logic              byte_last;
    logic              busy;
    logic              overrun;

    cubehash_digest_tx #(
        .HASH_W   (HASH_W),
        .MSB_FIRST(MSB_FIRST)
    ) dut (
        .clk       (clk),
        .rst_p     (rst_p),
        .hash_in   (hash_in),
        .hash_valid(hash_valid),
        .hash_ready(hash_ready),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .byte_first(byte_first),
        .byte_last (byte_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];   // bytes still owed by the DUT, oldest first
    logic [EW-1:0] pend_q[$];  // bytes of a digest captured at the coming edge
    logic ovr_model = 1'b0;
    logic ovr_next  = 1'b0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Digests occupying the buffer: a partly sent digest still holds its slot.
    function automatic int held();
        return (exp_q.size() + BYTES - 1) / BYTES;
    endfunction

    // Reference model: expand a digest into its byte sequence.
    task automatic push_digest(input logic [HASH_W-1:0] d);
        logic [HASH_W-1:0] t;
        logic [7:0] b;
        for (int i = 0; i < BYTES; i++) begin
            if (MSB_FIRST) t = d >> (HASH_W - 8 - 8 * i);
            else           t = d >> (8 * i);
            b = t[7:0];
            pend_q.push_back({(i == 0), (i == BYTES - 1), b});
        end
    endtask

    function automatic logic [HASH_W-1:0] rand_digest();
        logic [HASH_W-1:0] d;
        for (int i = 0; i < HASH_W / 32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // ---------------- driver ----------------
    // Drives one cycle at negedge+1 and returns after the monitor has run.
    task automatic step(input logic hv, input logic [HASH_W-1:0] hd, input logic br);
        @(negedge clk);
        #1;
        hash_valid = hv;
        hash_in    = hd;
        byte_ready = br;
        if (hv) begin
            if (held() < 2) push_digest(hd);
            else            ovr_next = 1'b1;
        end
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_hash_ready"}, hash_ready, 1'b1);
        chk8({tag, "_byte_out"}, byte_out, 8'h00);
        chk1({tag, "_byte_valid"}, byte_valid, 1'b0);
        chk1({tag, "_byte_first"}, byte_first, 1'b0);
        chk1({tag, "_byte_last"}, byte_last, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_overrun"}, overrun, 1'b0);
    endtask

    // Asserts reset between clock edges and checks outputs before any edge.
    task automatic async_reset();
        @(negedge clk);
        #1;
        hash_valid = 1'b0;
        byte_ready = 1'b1;
        rst_p = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        pend_q.delete();
        ovr_model = 1'b0;
        ovr_next  = 1'b0;
        @(negedge clk);
        #1;
        rst_p = 1'b0;
        #2;
    endtask

    // ---------------- monitor ----------------
    always begin : monitor
        logic [EW-1:0] e;
        @(negedge clk);
        #2;
        if (!rst_p) begin
            chk1("hash_ready", hash_ready, held() != 2);
            chk1("overrun", overrun, ovr_model);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                chk1("byte_valid", byte_valid, 1'b1);
                chk8("byte_out", byte_out, e[7:0]);
                chk1("byte_first", byte_first, e[9]);
                chk1("byte_last", byte_last, e[8]);
                chk1("busy", busy, 1'b1);
                if (byte_ready) void'(exp_q.pop_front());
            end else begin
                chk1("byte_valid_idle", byte_valid, 1'b0);
                chk8("byte_out_idle", byte_out, 8'h00);
                chk1("byte_first_idle", byte_first, 1'b0);
                chk1("byte_last_idle", byte_last, 1'b0);
                chk1("busy_idle", busy, 1'b0);
            end
            while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
            ovr_model = ovr_model | ovr_next;
            ovr_next  = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        logic [HASH_W-1:0] ramp;
        logic [HASH_W-1:0] dig_a;
        logic [HASH_W-1:0] dig_b;
        int n;

        for (int i = 0; i < BYTES; i++) ramp[HASH_W - 8 - 8 * i +: 8] = 8'(i);
        dig_a = {BYTES{8'hAA}};
        dig_b = {BYTES{8'h55}};

        rst_p      = 1'b0;
        hash_valid = 1'b0;
        byte_ready = 1'b0;
        hash_in    = '0;
        #1 rst_p = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        rst_p = 1'b0;
        #2;

        // Single digest with byte_ready held high.
        step(1'b1, ramp, 1'b1);
        repeat (40) step(1'b0, '0, 1'b1);

        // Same digest under alternating backpressure.
        step(1'b1, ramp, 1'b1);
        for (int i = 0; i < 70; i++) step(1'b0, '0, (i % 2) == 1);

        // Back-to-back digests, second strobe five cycles after the first.
        step(1'b1, dig_a, 1'b1);
        repeat (4) step(1'b0, '0, 1'b1);
        step(1'b1, dig_b, 1'b1);
        repeat (70) step(1'b0, '0, 1'b1);

        // Overrun: three strobes while the output is stalled.
        step(1'b1, dig_a, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, dig_b, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, ramp, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0);
        repeat (80) step(1'b0, '0, 1'b1);

        // Capture in the same cycle as the retire of the only held digest.
        step(1'b1, rand_digest(), 1'b1);
        n = 0;
        while (exp_q.size() != 1 && n < 100) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        checks++;
        if (exp_q.size() != 1) begin
            errors++;
            $display("FAIL wait_last_byte: got %0d bytes pending expected 1", exp_q.size());
        end
        step(1'b1, rand_digest(), 1'b1);
        repeat (40) step(1'b0, '0, 1'b1);

        // Reset in the middle of a digest, at byte 10.
        step(1'b1, ramp, 1'b1);
        n = 0;
        while (exp_q.size() > BYTES - 10 && n < 100) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        async_reset();
        step(1'b1, ramp, 1'b1);
        repeat (40) step(1'b0, '0, 1'b1);

        // Random traffic: sparse strobes, then dense strobes that overrun.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, (i < 1500) ? 47 : 11) == 0)
                step(1'b1, rand_digest(), $urandom_range(0, 3) != 0);
            else
                step(1'b0, '0, $urandom_range(0, 3) != 0);
        end

        // Drain everything still owed.
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
        end
        repeat (2) step(1'b0, '0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
